// File: rtl/stitch_wr_arbiter.sv
// Round-robin burst writer: shares one frame-buffer write port among three camera streams,
// placing each stream at its tile in the stitched frame. Macro STITCH_PINGPONG_EN adds per-channel frame banks.
module stitch_wr_arbiter #(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 24,
  parameter int BURST_LEN   = 64,
  parameter int STRIDE      = 1920,
  parameter int CH0_BASE    = 0,
  parameter int CH1_BASE    = 1920 * 1080,
  parameter int CH2_BASE    = 1920 * 1080 + 960,
  parameter int CH0_HDISP   = 1920,
  parameter int CH1_HDISP   = 960,
  parameter int CH2_HDISP   = 960,
  parameter int CH0_VDISP   = 1080,
  parameter int CH1_VDISP   = 540,
  parameter int CH2_VDISP   = 540,
  parameter int BANK_OFFSET = 1 << 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        frame_start,
  input  logic [2:0]        req,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic [DATA_W-1:0] ch2_data,
  output logic [2:0]        fifo_rd,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_last,
  output logic [2:0]        grant,
  output logic [2:0]        frame_done,
  output logic [2:0]        rd_bank
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int                BURST_SHIFT = $clog2(BURST_LEN);
  localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] BANK_A      = ADDR_W'(BANK_OFFSET);

  function automatic logic [ADDR_W-1:0] ch_base(input logic [1:0] c);
    case (c)
      2'd0:    ch_base = ADDR_W'(CH0_BASE);
      2'd1:    ch_base = ADDR_W'(CH1_BASE);
      default: ch_base = ADDR_W'(CH2_BASE);
    endcase
  endfunction

  function automatic logic [15:0] ch_last_col(input logic [1:0] c);
    case (c)
      2'd0:    ch_last_col = 16'(CH0_HDISP / BURST_LEN - 1);
      2'd1:    ch_last_col = 16'(CH1_HDISP / BURST_LEN - 1);
      default: ch_last_col = 16'(CH2_HDISP / BURST_LEN - 1);
    endcase
  endfunction

  function automatic logic [15:0] ch_last_line(input logic [1:0] c);
    case (c)
      2'd0:    ch_last_line = 16'(CH0_VDISP - 1);
      2'd1:    ch_last_line = 16'(CH1_VDISP - 1);
      default: ch_last_line = 16'(CH2_VDISP - 1);
    endcase
  endfunction

  // k-th candidate of the search that starts just after the last granted channel
  function automatic logic [1:0] rr_pick(input logic [1:0] lg, input logic [1:0] k);
    logic [2:0] sum;
    sum = {1'b0, lg} + {1'b0, k} + 3'd1;
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    rr_pick = sum[1:0];
  endfunction

  state_t            state_r;
  logic [2:0]        grant_r;
  logic [1:0]        last_grant_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [7:0]        beat_r;
  logic [2:0]        active_r;
  logic [2:0]        pend_r;
  logic [2:0]        bank_r;
  logic [2:0]        rd_bank_r;
  logic [2:0]        frame_done_r;
  logic [15:0]       col_r       [3];
  logic [15:0]       line_r      [3];
  logic [ADDR_W-1:0] line_base_r [3];

  logic [2:0]        pend_eff_s;
  logic [2:0]        busy_s;
  logic [2:0]        elig_s;
  logic [ADDR_W-1:0] addr_s [3];
  logic              hit_s;
  logic [1:0]        hit_idx_s;
  logic              burst_done_s;
  logic [DATA_W-1:0] wr_data_s;

  // Per-channel eligibility and next burst address; a channel with a restart pending waits one cycle
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      pend_eff_s[c] = pend_r[c] | frame_start[c];
      busy_s[c]     = (state_r != ST_IDLE) && grant_r[c];
      elig_s[c]     = req[c] & active_r[c] & ~pend_eff_s[c];
      addr_s[c]     = ch_base(2'(c)) + line_base_r[c] + (ADDR_W'(col_r[c]) << BURST_SHIFT)
                    + (bank_r[c] ? BANK_A : {ADDR_W{1'b0}});
    end
  end

  // Round-robin search
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!hit_s && elig_s[rr_pick(last_grant_r, 2'(k))]) begin
        hit_s     = 1'b1;
        hit_idx_s = rr_pick(last_grant_r, 2'(k));
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  assign burst_done_s = (state_r == ST_DATA) && wr_ready && (beat_r == LAST_BEAT);

  // Write-data mux from the granted channel's show-ahead FIFO head
  always_comb begin
    wr_data_s = {DATA_W{1'b0}};
    case (grant_r)
      3'b001:  wr_data_s = ch0_data;
      3'b010:  wr_data_s = ch1_data;
      3'b100:  wr_data_s = ch2_data;
      default: wr_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Burst sequencer plus per-channel frame position, restart and bank tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= 3'b000;
      last_grant_r <= 2'd2;
      cmd_addr_r   <= {ADDR_W{1'b0}};
      beat_r       <= 8'd0;
      active_r     <= 3'b000;
      pend_r       <= 3'b000;
      bank_r       <= 3'b000;
      rd_bank_r    <= 3'b000;
      frame_done_r <= 3'b000;
      for (int c = 0; c < 3; c++) begin
        col_r[c]       <= 16'd0;
        line_r[c]      <= 16'd0;
        line_base_r[c] <= {ADDR_W{1'b0}};
      end
    end else begin
      frame_done_r <= 3'b000;
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            grant_r      <= 3'b001 << hit_idx_s;
            cmd_addr_r   <= addr_s[hit_idx_s];
            last_grant_r <= hit_idx_s;
            state_r      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cmd_ready) begin
            beat_r  <= 8'd0;
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr_ready) begin
            if (beat_r == LAST_BEAT) begin
              grant_r <= 3'b000;
              state_r <= ST_IDLE;
            end else begin
              beat_r <= beat_r + 8'd1;
            end
          end
        end
        default: begin
          grant_r <= 3'b000;
          state_r <= ST_IDLE;
        end
      endcase

      for (int c = 0; c < 3; c++) begin
        if (burst_done_s && grant_r[c]) begin
          if (col_r[c] == ch_last_col(2'(c))) begin
            col_r[c]       <= 16'd0;
            line_base_r[c] <= line_base_r[c] + STRIDE_A;
            line_r[c]      <= line_r[c] + 16'd1;
            if (line_r[c] == ch_last_line(2'(c))) begin
              active_r[c]     <= 1'b0;
              frame_done_r[c] <= 1'b1;
              rd_bank_r[c]    <= bank_r[c];
            end
          end else begin
            col_r[c] <= col_r[c] + 16'd1;
          end
        end
        // A restart never coincides with a completion: completions only happen while busy
        if (pend_eff_s[c] && !busy_s[c]) begin
          pend_r[c]      <= 1'b0;
          active_r[c]    <= 1'b1;
          col_r[c]       <= 16'd0;
          line_r[c]      <= 16'd0;
          line_base_r[c] <= {ADDR_W{1'b0}};
`ifdef STITCH_PINGPONG_EN
          bank_r[c]      <= ~bank_r[c];
`else
          bank_r[c]      <= 1'b0;
`endif
        end else if (frame_start[c]) begin
          pend_r[c] <= 1'b1;
        end
      end
    end
  end

  assign cmd_valid  = (state_r == ST_CMD);
  assign cmd_addr   = cmd_addr_r;
  assign cmd_len    = LAST_BEAT;
  assign wr_valid   = (state_r == ST_DATA);
  assign wr_last    = (state_r == ST_DATA) && (beat_r == LAST_BEAT);
  assign wr_data    = wr_data_s;
  assign fifo_rd    = grant_r & {3{wr_valid & wr_ready}};
  assign grant      = grant_r;
  assign frame_done = frame_done_r;
  assign rd_bank    = rd_bank_r;

endmodule

// File: tb/tb_stitch_wr_arbiter.sv
// Bench for stitch_wr_arbiter: table of expected bursts (grant, address, frame_done) plus hand-written
// latency / mid-burst reset sequences. Bank expectations follow STITCH_PINGPONG_EN when defined.
module tb_stitch_wr_arbiter;

  localparam int AW = 28;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    frame_start;
  logic [2:0]    req;
  logic [DW-1:0] ch0_data, ch1_data, ch2_data;
  logic [2:0]    fifo_rd;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wr_valid, wr_ready, wr_last;
  logic [DW-1:0] wr_data;
  logic [2:0]    grant, frame_done, rd_bank;

  stitch_wr_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4), .STRIDE(16),
    .CH0_BASE(0), .CH1_BASE(8), .CH2_BASE(64),
    .CH0_HDISP(8), .CH1_HDISP(8), .CH2_HDISP(8),
    .CH0_VDISP(2), .CH1_VDISP(2), .CH2_VDISP(2),
    .BANK_OFFSET(128)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .req(req),
    .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data),
    .fifo_rd(fifo_rd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .grant(grant), .frame_done(frame_done), .rd_bank(rd_bank)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head word tags channel and pop count
  int pop [3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (fifo_rd[i]) pop[i] <= pop[i] + 1;
  end
  assign ch0_data = {4'd1, 20'(pop[0])};
  assign ch1_data = {4'd2, 20'(pop[1])};
  assign ch2_data = {4'd3, 20'(pop[2])};

  typedef struct {
    logic        rst_b;
    logic [2:0]  fs_b;
    logic [2:0]  req;
    logic [2:0]  fs_mid;
    logic        stall;
    logic [2:0]  grant;
    logic [27:0] addr;
    logic [2:0]  fd;
    logic        idle_chk;
  } vec_t;

  vec_t       vecs[$];
  int         base_a [3] = '{0, 8, 64};
  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] bank_m = 3'b000;
  logic [2:0] rdb_m = 3'b000;

  function automatic vec_t mk(input logic rb, input logic [2:0] fs, input logic [2:0] rq,
                              input logic [2:0] mid, input logic st, input logic [2:0] g,
                              input int a, input logic [2:0] fd, input logic ic);
    vec_t v;
    v = '{rb, fs, rq, mid, st, g, 28'(a), fd, ic};
    return v;
  endfunction

  function automatic int burst_off(input int b);
    return (b / 2) * 16 + (b % 2) * 4;
  endfunction

  task automatic add_frame(input int ch, input logic rb, input logic st, input logic ic);
    for (int b = 0; b < 4; b++)
      vecs.push_back(mk(b == 0 ? rb : 1'b0, b == 0 ? 3'(1 << ch) : 3'b000, 3'(1 << ch), 3'b000, st,
                        3'(1 << ch), base_a[ch] + burst_off(b), b == 3 ? 3'(1 << ch) : 3'b000,
                        b == 3 ? ic : 1'b0));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", 32'({cmd_valid, wr_valid, wr_last, fifo_rd, grant, frame_done, rd_bank}), 32'd0);
    check("rst_addr", 32'(cmd_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_len", 32'(cmd_len), 32'd3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 3'b000; frame_start = 3'b000; wr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0; bank_m = 3'b000; rdb_m = 3'b000;
  endtask

  task automatic pulse_fs(input logic [2:0] m);
    @(negedge clk);
    frame_start = m;
`ifdef STITCH_PINGPONG_EN
    bank_m = bank_m ^ m;
`endif
    @(negedge clk);
    frame_start = 3'b000;
  endtask

  task automatic run_burst(input vec_t v);
    int          ch, waited, beats;
    logic [27:0] exp_a;
    logic [DW-1:0] hold_d;
    logic        hold_v, rdy;
    ch     = v.grant[1] ? 1 : (v.grant[2] ? 2 : 0);
    exp_a  = v.addr + (bank_m[ch] ? 28'd128 : 28'd0);
    waited = 0;
    do begin
      @(negedge clk); #1; waited++;
    end while (!cmd_valid && waited < 20);
    check("cmd_valid", 32'(cmd_valid), 32'd1);
    if (!cmd_valid) return;
    check("grant", 32'(grant), 32'(v.grant));
    check("cmd_addr", 32'(cmd_addr), 32'(exp_a));
    check("cmd_len", 32'(cmd_len), 32'd3);
    beats = 0; waited = 0; hold_v = 1'b0; rdy = 1'b1; hold_d = '0;
    while (beats < 4 && waited < 40) begin
      @(negedge clk);
      wr_ready    = rdy;
      frame_start = (waited == 0) ? v.fs_mid : 3'b000;
`ifdef STITCH_PINGPONG_EN
      if (waited == 0) bank_m = bank_m ^ v.fs_mid;
`endif
      #1;
      check("wr_valid", 32'(wr_valid), 32'd1);
      if (wr_valid && wr_ready) begin
        check("fifo_rd", 32'(fifo_rd), 32'(v.grant));
        check("wr_last", 32'(wr_last), 32'(beats == 3));
        check("wr_data", 32'(wr_data), 32'({4'(ch + 1), 20'(pop[ch])}));
        if (hold_v) check("stall_hold", 32'(wr_data), 32'(hold_d));
        hold_v = 1'b0;
        beats++;
      end else begin
        check("stall_rd", 32'(fifo_rd), 32'd0);
        hold_d = wr_data;
        hold_v = 1'b1;
      end
      rdy = v.stall ? ~rdy : 1'b1;
      waited++;
    end
    check("beat_count", 32'(beats), 32'd4);
    wr_ready = 1'b1; frame_start = 3'b000;
    @(negedge clk); #1;
    check("gap", 32'({cmd_valid, wr_valid}), 32'd0);
    check("frame_done", 32'(frame_done), 32'(v.fd));
    for (int i = 0; i < 3; i++) if (v.fd[i]) rdb_m[i] = bank_m[i];
    check("rd_bank", 32'(rd_bank), 32'(rdb_m));
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req = 3'b000; frame_start = 3'b000; cmd_ready = 1'b1; wr_ready = 1'b1;

    // Single channel, round-robin, back-pressure, mid-burst restart, two-frame bank check
    add_frame(0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      int ch, b;
      ch = k % 3; b = k / 3;
      vecs.push_back(mk(k == 0, k == 0 ? 3'b111 : 3'b000, 3'b111, 3'b000, 1'b0, 3'(1 << ch),
                        base_a[ch] + burst_off(b), b == 3 ? 3'(1 << ch) : 3'b000, k == 11));
    end
    add_frame(2, 1'b1, 1'b1, 1'b0);
    vecs.push_back(mk(1'b1, 3'b010, 3'b010, 3'b000, 1'b0, 3'b010, 8,  3'b000, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 3'b010, 12, 3'b000, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 8,  3'b000, 1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 12, 3'b000, 1'b0));
    add_frame(0, 1'b1, 1'b0, 1'b0);
    add_frame(0, 1'b0, 1'b0, 1'b0);

    do_reset();

    // Latency from frame_start, then reset in the middle of a data phase
    req = 3'b001;
    pulse_fs(3'b001);
    #1;
    check("lat_idle", 32'(cmd_valid), 32'd0);
    @(negedge clk); #1;
    check("lat_cmd", 32'({cmd_valid, grant}), 32'({1'b1, 3'b001}));
    @(negedge clk); #1;
    check("lat_data", 32'(wr_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs();
    rst = 1'b0; bank_m = 3'b000; rdb_m = 3'b000; req = 3'b111;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk); #1; seen |= cmd_valid;
    end
    check("inactive_req", 32'(seen), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_b) do_reset();
      req = vecs[i].req;
      if (vecs[i].fs_b != 3'b000) pulse_fs(vecs[i].fs_b);
      run_burst(vecs[i]);
      if (vecs[i].idle_chk) begin
        seen = 1'b0;
        repeat (8) begin
          @(negedge clk); #1; seen |= cmd_valid;
        end
        check("no_more_cmd", 32'(seen), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stitch_wr_arbiter.md
# stitch_wr_arbiter

Round-robin scheduler that shares one frame-buffer write port among the three camera streams of the video-stitching path. Each camera feeds a clock-crossing show-ahead FIFO. When a FIFO holds a full burst, this block issues one write command for that burst and moves its pixels to memory. It places each stream's pixels at that stream's tile position inside the shared stitched frame, e.g. 1920x1080 main view plus two 960x540 insets.

## Interface
- ADDR_W, 28, word address width (one pixel per word)
- DATA_W, 24, pixel width (RGB888)
- BURST_LEN, 64, beats per burst; power of two, ≤256
- STRIDE, 1920, stitched-frame line pitch in words
- CH0_BASE / CH1_BASE / CH2_BASE, 0 / 1920*1080 / 1920*1080+960, tile origin word address
- CH0_HDISP / CH1_HDISP / CH2_HDISP, 1920 / 960 / 960, tile width; multiple of BURST_LEN
- CH0_VDISP / CH1_VDISP / CH2_VDISP, 1080 / 540 / 540, tile height
- BANK_OFFSET, 1<<23, word offset of bank 1 (used only with STITCH_PINGPONG_EN)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- frame_start  in  3  per-channel one-cycle pulse at frame start, already in clk domain
- req  in  3  per-channel: FIFO level ≥ BURST_LEN
- ch0_data / ch1_data / ch2_data  in  DATA_W  show-ahead FIFO heads
- fifo_rd  out  3  per-channel pop strobe
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  memory controller accepts command
- cmd_addr  out  ADDR_W  burst start word address
- cmd_len  out  8  BURST_LEN-1, held constant
- wr_valid  out  1  write beat valid
- wr_ready  in  1  memory controller accepts beat
- wr_data  out  DATA_W  granted channel's FIFO head
- wr_last  out  1  final beat of burst
- grant  out  3  one-hot granted channel; 0 when idle
- frame_done  out  3  one-cycle pulse when a channel's last burst of the frame completes
- rd_bank  out  3  per-channel bank most recently completed

## Operation
- States: IDLE → CMD → DATA → IDLE.
- **IDLE:**
  - A channel is eligible when req=1 and it is active.
  - A channel is active from frame_start until its last burst completes.
  - Round-robin search starts at last_grant+1 mod 3; last_grant resets to 2, so ch0 is searched first.
  - On a hit: register grant, cmd_addr and last_grant; go to CMD.
- **CMD:** cmd_valid=1 and cmd_addr stable until cmd_valid&cmd_ready; then go to DATA.
- **DATA:**
  - wr_valid=1 and wr_data = head of the granted channel.
  - fifo_rd[g] = wr_valid&wr_ready, combinational.
  - A beat counter counts handshakes; wr_last=1 when the count is BURST_LEN-1.
  - On the last handshake, advance that channel's counters and go to IDLE.
- **Per-channel address:**
  - cmd_addr = BASE + line_base + col*BURST_LEN (+BANK_OFFSET when bank=1).
  - line_base steps by STRIDE; arithmetic is modulo 2^ADDR_W.
- **Counter advance at burst completion:**
  - col increments.
  - When col = HDISP/BURST_LEN-1: col←0, line_base += STRIDE, line increments.
  - When line = VDISP-1 also holds: channel goes inactive, frame_done pulses, rd_bank ← current bank.
- **frame_start:**
  - Latched as pending.
  - Applied in the first cycle the channel is not granted in CMD/DATA: col=line=line_base=0, channel active.
  - With the macro enabled, the bank also toggles.
  - A frame_start landing mid-burst lets that burst finish at its old address.
- **Same-cycle frame_start and last-burst completion on one channel:** frame_done still pulses, then the restart applies. The channel ends active at address 0.
- **After reset:** all channels are inactive until their first frame_start. No partial-frame writes.
- **req while inactive:** ignored. The FIFO fills; overflow handling is upstream.

## Timing
- **Reset:** every output is 0 except cmd_len = BURST_LEN-1. State = IDLE, all counters 0, banks 0, pending flags cleared.
- **Reset mid-burst:** cmd_valid/wr_valid drop at the next edge. The burst is abandoned; the integrator must flush the FIFOs.
- **Latency:** eligible req in IDLE at cycle t → cmd_valid at t+1. With cmd_ready=1 at t+1, the first wr_valid is at t+2.
- **Burst length:** exactly BURST_LEN handshakes.
- **Gap:** at least one IDLE cycle between wr_last and the next cmd_valid.
- **Back-pressure:** wr_ready=0 stalls. wr_data and wr_last hold and fifo_rd stays 0.
- **frame_done:** asserts in the cycle after the final wr_last handshake.

## Configuration
- **STITCH_PINGPONG_EN defined:**
  - Each channel keeps a bank bit, toggled when a frame_start is applied; the first frame uses bank 1.
  - Addresses in bank 1 add BANK_OFFSET.
  - rd_bank reports the bank of the last finished frame, so the reader never scans a frame being written.
- **Not defined:**
  - Bank is fixed at 0; BANK_OFFSET has no effect; rd_bank = 0.

## Test plan
Bench parameters: BURST_LEN=4, STRIDE=16, CH0_BASE=0, CH1_BASE=8, CH2_BASE=64, all HDISP=8, all VDISP=2, cmd_ready=wr_ready=1.

- **Single channel:** frame_start[0], req[0] held high → four bursts at addrs 0, 4, 16, 20; frame_done[0] pulses once; no further cmd while req held.
- **Round-robin:** all channels started, all req high → grant order ch0, ch1, ch2, ch0…; first addrs 0, 8, 64, 4.
- **Back-pressure:** wr_ready toggled 1,0 repeatedly → exactly 4 fifo_rd pulses per burst; wr_data/wr_last stable during stalls.
- **Mid-burst restart:** frame_start[1] during ch1's second burst (addr 12) → that burst completes at 12; ch1's next cmd_addr is 8.
- **Reset:** rst during DATA → all outputs 0 at the next edge; req ignored until a new frame_start.
- **Ping-pong (macro on, BANK_OFFSET=128):** two frames on ch0 → first burst addrs 128 then 0; rd_bank[0] = 1 after frame 1, 0 after frame 2.
